// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter that shares one APB slave port between NUM_REQ
// internal requesters and runs each granted transfer as a SETUP/ACCESS pair.
// Every output is a flop. A transfer aborts if PREADY stays low for
// TIMEOUT_CYCLES ACCESS cycles; TIMEOUT_CYCLES = 0 disables the abort.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no transfer in flight; pick the next eligible requester
// ST_SETUP  | PSELx=1, PENABLE=0 for exactly one cycle
// ST_ACCESS | PSELx=1, PENABLE=1; wait for PREADY or the timeout
module apb_rr_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_grant,
  output logic [NUM_REQ-1:0]               req_done,
  output logic                             req_err,
  output logic [DATA_WIDTH-1:0]            req_rdata,
  output logic                             PSELx,
  output logic                             PENABLE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  input  logic [DATA_WIDTH-1:0]            PRDATA,
  input  logic                             PREADY
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PW-1:0] PTR_RST  = PW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam bit            TO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [PW-1:0]           r_ptr;
  logic [PW-1:0]           w_ptr_nxt;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           w_cnt_nxt;

  logic [NUM_REQ-1:0]      w_eligible;
  logic                    w_hi_found;
  logic [PW-1:0]           w_hi;
  logic                    w_lo_found;
  logic [PW-1:0]           w_lo;
  logic                    w_found;
  logic [PW-1:0]           w_pick;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [DATA_WIDTH-1:0]   w_sel_wdata;
  logic                    w_sel_write;
  logic                    w_timeout;

  logic [NUM_REQ-1:0]      w_grant_nxt;
  logic [NUM_REQ-1:0]      w_done_nxt;
  logic                    w_err_nxt;
  logic [DATA_WIDTH-1:0]   w_rdata_nxt;
  logic                    w_psel_nxt;
  logic                    w_pen_nxt;
  logic [ADDR_WIDTH-1:0]   w_paddr_nxt;
  logic                    w_pwrite_nxt;
  logic [DATA_WIDTH-1:0]   w_pwdata_nxt;

  // A requester whose done pulse is high this cycle is not re-granted.
  assign w_eligible = req_valid & ~req_done;
  assign w_timeout  = TO_EN && (r_cnt == CNT_LAST) && !PREADY;

  // Round-robin search: lowest eligible index above the pointer, else lowest overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi       = '0;
    w_lo_found = 1'b0;
    w_lo       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_lo_found = 1'b1;
        w_lo       = PW'(i);
        if (PW'(i) > r_ptr) begin
          w_hi_found = 1'b1;
          w_hi       = PW'(i);
        end
      end
    end
  end

  assign w_found = w_lo_found;
  assign w_pick  = w_hi_found ? w_hi : w_lo;

  // Select the winning requester's address, data and direction.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PW'(i) == w_pick) begin
        w_sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_write = req_write[i];
      end
    end
  end

  // State register.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_found) w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (PREADY || w_timeout) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and wait counter.
  always_comb begin
    w_grant_nxt  = req_grant;
    w_done_nxt   = '0;
    w_err_nxt    = 1'b0;
    w_rdata_nxt  = req_rdata;
    w_psel_nxt   = PSELx;
    w_pen_nxt    = PENABLE;
    w_paddr_nxt  = PADDR;
    w_pwrite_nxt = PWRITE;
    w_pwdata_nxt = PWDATA;
    w_ptr_nxt    = r_ptr;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_nxt  = NUM_REQ'(1) << w_pick;
          w_paddr_nxt  = w_sel_addr;
          w_pwrite_nxt = w_sel_write;
          w_pwdata_nxt = w_sel_wdata;
          w_psel_nxt   = 1'b1;
          w_pen_nxt    = 1'b0;
          w_ptr_nxt    = w_pick;
        end
      end
      ST_SETUP: begin
        w_pen_nxt = 1'b1;
        w_cnt_nxt = '0;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          w_psel_nxt  = 1'b0;
          w_pen_nxt   = 1'b0;
          w_grant_nxt = '0;
          w_done_nxt  = req_grant;
          if (!PWRITE) w_rdata_nxt = PRDATA;
        end else if (w_timeout) begin
          w_psel_nxt  = 1'b0;
          w_pen_nxt   = 1'b0;
          w_grant_nxt = '0;
          w_done_nxt  = req_grant;
          w_err_nxt   = 1'b1;
          w_rdata_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output, pointer and counter registers; reset leaves requester 0 first in line.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      req_grant <= '0;
      req_done  <= '0;
      req_err   <= 1'b0;
      req_rdata <= '0;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      r_ptr     <= PTR_RST;
      r_cnt     <= '0;
    end else begin
      req_grant <= w_grant_nxt;
      req_done  <= w_done_nxt;
      req_err   <= w_err_nxt;
      req_rdata <= w_rdata_nxt;
      PSELx     <= w_psel_nxt;
      PENABLE   <= w_pen_nxt;
      PADDR     <= w_paddr_nxt;
      PWRITE    <= w_pwrite_nxt;
      PWDATA    <= w_pwdata_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
- Round-robin APB requester arbiter and transfer sequencer.
- Shares one APB slave port between NUM_REQ internal requesters.
- Grants one requester at a time, then runs a complete SETUP/ACCESS transfer on the APB signals (PSELx, PENABLE, PADDR, PWRITE, PWDATA, PRDATA, PREADY).
- Returns read data and completion/error status to the granted requester. Sits in place of the single-source APB master in front of APB_slave.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 32, PADDR and request address width.
- DATA_WIDTH, 32, PWDATA/PRDATA width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles waiting for PREADY before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  clock; all state updates on the rising edge.
- PRESET  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester transfer request, level.
- req_write  in  NUM_REQ  per-requester direction: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data, sliced the same way.
- req_grant  out  NUM_REQ  one-hot owner of the current transfer.
- req_done  out  NUM_REQ  one-cycle completion pulse to the owner.
- req_err  out  1  valid with req_done: 1 = transfer aborted by timeout.
- req_rdata  out  DATA_WIDTH  read data, valid with req_done.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PADDR  out  ADDR_WIDTH  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- All outputs are registered.
- Reset (async, PRESET=0): state=IDLE. All outputs 0. Round-robin pointer = NUM_REQ-1, so requester 0 has first priority. Wait counter = 0.
- Reset mid-transfer aborts immediately: bus signals drop to 0 and no req_done is issued.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - Eligible requesters: req_valid[i]=1 and req_done[i]=0 in that cycle. A requester is never re-granted in the cycle its done pulse is high.
  - If any requester is eligible, pick the first eligible index searching upward from pointer+1 with wrap-around.
  - At that edge: req_grant=onehot(i); latch PADDR, PWRITE, PWDATA from slice i; PSELx=1; PENABLE=0; pointer=i; go to SETUP.
  - If no requester is eligible, stay in IDLE with req_grant=0.
- SETUP: exactly one cycle. Next edge: PENABLE=1, counter=0, go to ACCESS.
- ACCESS, PREADY=1 sampled:
  - PSELx=0, PENABLE=0, req_grant=0.
  - req_done[i]=1 for one cycle, req_err=0.
  - req_rdata=PRDATA on a read; req_rdata is unchanged on a write.
  - Go to IDLE.
- ACCESS, PREADY=0: counter increments.
  - If TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES-1 with PREADY still 0: abort with PSELx=0, PENABLE=0, req_done[i]=1, req_err=1, req_rdata=0, then go to IDLE.
  - PREADY=1 on the timeout cycle counts as normal completion.
- Minimum transfer: grant edge, then SETUP, ACCESS, and one IDLE cycle, i.e. 3 cycles per zero-wait transfer. No back-to-back SETUP.
- PADDR, PWRITE and PWDATA hold their values from grant until the next grant, including through IDLE.
- Requester rules:
  - Hold req_write, req_addr and req_wdata stable while req_valid=1, until req_done.
  - Deassert req_valid by the cycle after req_done unless issuing a new transfer.
  - Dropping req_valid while granted has no effect; the transfer completes.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 transfers.
- req_done and req_err are 0 in every cycle without a completion.

Test Plan:
- Single write: req 0 writes addr 0x10, data 0xDEADBEEF, PREADY=1 → PSELx high 2 cycles, PENABLE high in the 2nd, PWRITE=1, PADDR=0x10; req_done=4'b0001, req_err=0.
- Read with 3 wait states: req 2 reads addr 0x20; slave holds PREADY=0 for 3 ACCESS cycles, then PRDATA=0x12345678 → ACCESS lasts 4 cycles; req_done=4'b0100, req_rdata=0x12345678.
- Round-robin: all 4 requesters held valid from reset → grant order 0,1,2,3,0; each req_done pulses once per transfer; no requester is granted twice consecutively.
- Timeout: PREADY stuck 0, TIMEOUT_CYCLES=16 → abort after 16 ACCESS cycles; req_done pulse with req_err=1, req_rdata=0; the next pending requester is granted afterwards.
- Reset mid-ACCESS: assert PRESET=0 during a wait state → PSELx, PENABLE, req_grant drop asynchronously; no req_done; after release, requester 0 wins first.
- Done masking: requester 1 keeps req_valid high one cycle after its done, while requester 3 is also valid → requester 3 is granted, not requester 1.
